// File: rtl/imem_dmem_port_arbiter_if.sv
// Bus bundle between the pipeline requesters (IF, DM), the shared memory port and the arbiter.
// The slave modport is the arbiter's view; the master modport is the core/memory side.
interface imem_dmem_port_arbiter_if #(
    parameter int ADDR_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [63:0]       dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [63:0]       dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [63:0]       mem_rdata;

    logic              stall_if;
    logic              stall_mem;
    logic [31:0]       perf_conflict_cnt;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem,
               perf_conflict_cnt
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem,
               perf_conflict_cnt
    );
endinterface

// File: rtl/imem_dmem_port_arbiter.sv
// Single-outstanding arbiter sharing one 64-bit memory port between IF and DM with anti-starvation.
// Optional contention counter enabled by defining ARB_PERF_CNT_EN.
module imem_dmem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    imem_dmem_port_arbiter_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state_reg,      state_next;
    logic [2:0]  lat_cnt_reg,    lat_cnt_next;
    logic [3:0]  starve_cnt_reg, starve_cnt_next;
    logic        word_sel_reg,   word_sel_next;
    logic        store_reg,      store_next;

    logic        grant_if;
    logic        grant_dm;
    logic        resp_done;

    logic              if_rvalid_int;
    logic              dm_rvalid_int;
    logic [ADDR_W-1:0] issue_addr;

    logic [31:0] mem_word [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_word
        assign mem_word[gi] = bus.mem_rdata[gi*32 +: 32];
    end

    // Grant is combinational off IDLE so the winner issues in the same cycle it asks.
    always_comb begin
        grant_if  = 1'b0;
        grant_dm  = 1'b0;
        resp_done = 1'b0;
        if (state_reg == IDLE) begin
            grant_if = bus.if_req && (!bus.dm_req || (starve_cnt_reg == STARVE_LIM));
            grant_dm = bus.dm_req && !grant_if;
        end
        if ((state_reg != IDLE) && (lat_cnt_reg == 3'd0)) begin
            resp_done = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            lat_cnt_reg    <= 3'd0;
            starve_cnt_reg <= 4'd0;
            word_sel_reg   <= 1'b0;
            store_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            lat_cnt_reg    <= lat_cnt_next;
            starve_cnt_reg <= starve_cnt_next;
            word_sel_reg   <= word_sel_next;
            store_reg      <= store_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        lat_cnt_next    = lat_cnt_reg;
        starve_cnt_next = starve_cnt_reg;
        word_sel_next   = word_sel_reg;
        store_next      = store_reg;
        case (state_reg)
            IDLE: begin
                if (grant_if) begin
                    state_next      = BUSY_IF;
                    lat_cnt_next    = LAT_LOAD;
                    word_sel_next   = bus.if_addr[2];
                    starve_cnt_next = 4'd0;
                end else if (grant_dm) begin
                    state_next   = BUSY_DM;
                    lat_cnt_next = LAT_LOAD;
                    store_next   = bus.dm_we;
                    if (bus.if_req && (starve_cnt_reg < STARVE_LIM)) begin
                        starve_cnt_next = starve_cnt_reg + 4'd1;
                    end
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (lat_cnt_reg == 3'd0) begin
                    state_next = IDLE;
                end else begin
                    lat_cnt_next = lat_cnt_reg - 3'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Every output is forced low while reset is held, including the combinational grant path.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = 64'd0;
        bus.if_gnt    = 1'b0;
        bus.dm_gnt    = 1'b0;
        bus.if_rdata  = 32'd0;
        bus.dm_rdata  = 64'd0;
        issue_addr    = '0;
        if_rvalid_int = 1'b0;
        dm_rvalid_int = 1'b0;
        if (reset) begin
            bus.mem_en = grant_if || grant_dm;
            bus.if_gnt = grant_if;
            bus.dm_gnt = grant_dm;
            if (grant_if) begin
                issue_addr = bus.if_addr;
            end else if (grant_dm) begin
                bus.mem_we    = bus.dm_we;
                issue_addr    = bus.dm_addr;
                bus.mem_wdata = bus.dm_wdata;
            end
            if (resp_done && (state_reg == BUSY_IF)) begin
                if_rvalid_int = 1'b1;
                bus.if_rdata  = mem_word[word_sel_reg];
            end
            if (resp_done && (state_reg == BUSY_DM)) begin
                dm_rvalid_int = 1'b1;
                bus.dm_rdata  = store_reg ? 64'd0 : bus.mem_rdata;
            end
        end
        bus.mem_addr  = issue_addr;
        bus.if_rvalid = if_rvalid_int;
        bus.dm_rvalid = dm_rvalid_int;
        bus.stall_if  = reset && bus.if_req && !if_rvalid_int;
        bus.stall_mem = reset && bus.dm_req && !dm_rvalid_int;
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cnt_reg <= 32'd0;
        end else if ((state_reg == IDLE) && bus.if_req && bus.dm_req) begin
            perf_cnt_reg <= perf_cnt_reg + 32'd1;
        end
    end

    assign bus.perf_conflict_cnt = perf_cnt_reg;
`else
    assign bus.perf_conflict_cnt = 32'd0;
`endif

endmodule

// File: doc/imem_dmem_port_arbiter.md
Name: imem_dmem_port_arbiter

Overview:
Shares one unified 64-bit memory port between the pipeline's instruction-fetch requester (IF) and data-memory requester (DM, the MEM stage).
- One transaction in flight at a time; fixed memory latency.
- Drives per-stage stall outputs into the hazard/pipeline-register write enables (PC write, IF/ID write, EX/MEM hold).
- Sits between the pipeline core and the memory macro, replacing the separate instruction/data memory paths.

Parameters:
ADDR_W, 64, address width of both requesters and the memory port
MEM_LAT, 2, cycles from mem_en issue to valid mem_rdata; legal range 1..7
STARVE_MAX, 3, consecutive DM wins while IF waits before IF is forced to win; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; asserted when 0
if_req  in  1  IF read request, held until if_rvalid
if_addr  in  ADDR_W  IF byte address, stable while if_req=1
if_gnt  out  1  one-cycle pulse on the IF issue cycle
if_rvalid  out  1  one-cycle pulse; if_rdata valid
if_rdata  out  32  fetched instruction word
dm_req  in  1  DM request, held until dm_rvalid
dm_we  in  1  1=store, 0=load; stable with dm_req
dm_addr  in  ADDR_W  DM byte address
dm_wdata  in  64  store data
dm_gnt  out  1  one-cycle pulse on the DM issue cycle
dm_rvalid  out  1  one-cycle pulse; load data valid or store acknowledged
dm_rdata  out  64  load data; 0 for store acks
mem_en  out  1  one-cycle issue strobe to memory
mem_we  out  1  write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address, qualified by mem_en
mem_wdata  out  64  memory write data, qualified by mem_en
mem_rdata  in  64  memory read data, valid MEM_LAT cycles after mem_en
stall_if  out  1  if_req & ~if_rvalid
stall_mem  out  1  dm_req & ~dm_rvalid
perf_conflict_cnt  out  32  contention counter (see Optional Feature)

Behaviour:
- FSM states: IDLE, BUSY_IF, BUSY_DM. Reset value is IDLE.
- While reset=0, all outputs are 0, lat_cnt=0, starve_cnt=0, and any in-flight transaction is discarded.
- Memory responses arriving after reset deasserts are ignored, because no state is BUSY.
- IDLE arbitration, evaluated in the same cycle (combinational grant):
  - Only if_req: grant IF.
  - Only dm_req: grant DM.
  - Both requests: grant IF if starve_cnt==STARVE_MAX, otherwise grant DM.
  - Neither request: stay in IDLE; mem_en=0.
- Issue cycle T:
  - mem_en=1; the winner's gnt=1.
  - For IF: mem_we=0, mem_addr=if_addr.
  - For DM: mem_we=dm_we, mem_addr=dm_addr, mem_wdata=dm_wdata.
  - Latch owner, latch if_addr[2] (word select), and load lat_cnt=MEM_LAT-1.
  - Next state is BUSY_IF or BUSY_DM.
- In BUSY: mem_en=0; lat_cnt decrements each cycle.
- In the cycle lat_cnt==0 (cycle T+MEM_LAT), the owner's rvalid=1 and data is passed through combinationally:
  - IF: if_rdata = latched bit2 ? mem_rdata[63:32] : mem_rdata[31:0].
  - DM load: dm_rdata = mem_rdata.
  - DM store: dm_rdata = 0.
  - Next state is IDLE.
- Earliest next issue is T+MEM_LAT+1, giving a peak throughput of 1 transaction per MEM_LAT+1 cycles.
- rdata outputs are 0 whenever rvalid=0.
- starve_cnt (4-bit):
  - Increments, saturating at STARVE_MAX, on each DM issue where if_req=1.
  - Clears on each IF issue.
  - Otherwise holds.
- stall_if and stall_mem are combinational from the current-cycle req and rvalid. A requester sees stall=0 only in its rvalid cycle, or when idle.
- If a requester drops req while it owns the port (protocol violation), the transaction still completes and rvalid still pulses.
- Address bits [1:0] are not checked; alignment is the requester's responsibility.

Optional Feature:
Macro ARB_PERF_CNT_EN.
- Defined:
  - perf_conflict_cnt increments by 1 on every cycle where if_req=1 and dm_req=1 and the FSM is in IDLE.
  - Counts every such cycle; wraps modulo 2^32.
  - Resets to 0.
- Undefined: perf_conflict_cnt is tied to 0 and no counter flops are synthesized.

Test Plan:
1. MEM_LAT=2, IF only, if_addr=0x104, mem_rdata=0xAAAA_BBBB_1111_2222 -> mem_en at T, if_rvalid at T+2, if_rdata=0xAAAABBBB, stall_if high T..T+1, low at T+2.
2. DM store dm_addr=0x40, dm_wdata=0x1234, then DM load from 0x40 with memory model echoing -> mem_we=1 at first issue; dm_rvalid pulses with dm_rdata=0; second issue at T+3; load returns 0x1234 at T+5.
3. IF and DM both held continuously, STARVE_MAX=3 -> grant order DM, DM, DM, IF, DM, DM, DM, IF; issues spaced by 3 cycles; starve_cnt clears after each IF grant.
4. Reset pulled low at T+1 during BUSY_DM -> all outputs 0 immediately (async); after release, no dm_rvalid for the aborted load; a fresh dm_req is granted on the first cycle after release.
5. MEM_LAT=1 with back-to-back IF requests -> mem_en at T, T+2, T+4; if_rvalid at T+1, T+3, T+5.
6. ARB_PERF_CNT_EN defined, both requesters held for 12 cycles from IDLE with MEM_LAT=2 -> perf_conflict_cnt=4. Macro undefined -> perf_conflict_cnt stays 0.
